// File: rtl/div_nr_seq_if.sv
// rtl/div_nr_seq_if.sv - request/result bundle between the EX stage and the divider
interface div_nr_seq_if #(parameter int WIDTH = 32);
  logic             start;
  logic             signed_en;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             flush;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_en, dividend, divisor, flush,
    input  busy, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_en, dividend, divisor, flush,
    output busy, valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_nr_seq.sv
// rtl/div_nr_seq.sv - radix-2 non-restoring sequential divider, one add/subtract row per cycle
module div_nr_seq #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  div_nr_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ZERO, CALC, FIX} state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   p_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_mag;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH:0]   d_ext;
  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   p_next;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] q_fin;
  logic [WIDTH-1:0] r_fin;
  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;

  always_comb begin
    dvd_neg = bus.signed_en & bus.dividend[WIDTH-1];
    dvs_neg = bus.signed_en & bus.divisor[WIDTH-1];
    dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag = dvs_neg ? -bus.divisor : bus.divisor;
    d_ext   = {1'b0, d_mag};
    // The sign of the previous partial remainder selects add or subtract.
    p_shift = {p_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    p_next  = p_reg[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    p_fix   = p_reg[WIDTH] ? (p_reg + d_ext) : p_reg;
    q_fin   = neg_q ? -q_reg : q_reg;
    r_fin   = neg_r ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      p_reg           <= '0;
      q_reg           <= '0;
      d_mag           <= '0;
      neg_q           <= 1'b0;
      neg_r           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.valid       <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (bus.flush) begin
      state     <= IDLE;
      bus.busy  <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.valid <= 1'b0;
          // busy is still high during the valid cycle, which blocks a start there.
          if (bus.start && !bus.busy) begin
            bus.busy <= 1'b1;
            p_reg    <= '0;
            d_mag    <= dvs_mag;
            neg_q    <= dvd_neg ^ dvs_neg;
            neg_r    <= dvd_neg;
            count    <= CW'(WIDTH - 1);
            if (bus.divisor == '0) begin
              q_reg <= bus.dividend;
              state <= ZERO;
            end else begin
              q_reg <= dvd_mag;
              state <= CALC;
            end
          end else begin
            bus.busy <= 1'b0;
          end
        end
        ZERO: begin
          bus.quotient    <= '1;
          bus.remainder   <= q_reg;
          bus.div_by_zero <= 1'b1;
          bus.valid       <= 1'b1;
          state           <= IDLE;
        end
        CALC: begin
          p_reg <= p_next;
          q_reg <= {q_reg[WIDTH-2:0], ~p_next[WIDTH]};
          count <= count - CW'(1);
          if (count == '0) state <= FIX;
        end
        FIX: begin
          bus.quotient    <= q_fin;
          bus.remainder   <= r_fin;
          bus.div_by_zero <= 1'b0;
          bus.valid       <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_nr_seq.sv
// tb/tb_div_nr_seq.sv - directed bench for div_nr_seq with hand-computed results
module tb_div_nr_seq;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  div_nr_seq_if #(.WIDTH(32)) bus();

  div_nr_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle 0 holds start; lat is the cycle index at which valid is seen (capped at 200).
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int poke,
                        output int lat, output bit busy_all, output bit post_valid, output bit post_busy);
    bus.start = 1'b1; bus.signed_en = sgn; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom; bus.signed_en = ~sgn;
    lat = 1; busy_all = 1'b1;
    while (!bus.valid && lat < 200) begin
      if (!bus.busy) busy_all = 1'b0;
      if (lat == poke) begin
        bus.start = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.busy) busy_all = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    post_valid = bus.valid;
    post_busy  = bus.busy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.start = 1'b0; bus.flush = 1'b0; bus.signed_en = 1'b0;
    bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    n_checks++; if (bus.quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient got %h want 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder got %h want 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz got %b want 0", bus.div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int lat; bit ba, pv, pb;
    run_op(1'b0, 32'd100, 32'd7, 0, lat, ba, pv, pb);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL u100_7_latency got %0d want 34", lat); end
    n_checks++; if (bus.quotient !== 32'd14) begin n_fail++; $display("FAIL u100_7_q got %0d want 14", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'd2) begin n_fail++; $display("FAIL u100_7_r got %0d want 2", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL u100_7_dbz got %b want 0", bus.div_by_zero); end
    n_checks++; if (ba !== 1'b1) begin n_fail++; $display("FAIL u100_7_busy_window got %b want 1", ba); end
    n_checks++; if (pv !== 1'b0) begin n_fail++; $display("FAIL u100_7_valid_twice got %b want 0", pv); end
    n_checks++; if (pb !== 1'b0) begin n_fail++; $display("FAIL u100_7_busy_after got %b want 0", pb); end
  endtask

  task automatic test_signed();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    bit          sg [3];
    int lat; bit ba, pv, pb;
    va = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9};
    vb = '{32'h00000002, 32'hFFFFFFFE, 32'h00000002};
    sg = '{1'b1, 1'b1, 1'b0};
    eq = '{32'hFFFFFFFD, 32'hFFFFFFFD, 32'h7FFFFFFC};
    er = '{32'hFFFFFFFF, 32'h00000001, 32'h00000001};
    for (int i = 0; i < 3; i++) begin
      run_op(sg[i], va[i], vb[i], 0, lat, ba, pv, pb);
      n_checks++; if (bus.quotient !== eq[i]) begin n_fail++; $display("FAIL sign_q[%0d] got %h want %h", i, bus.quotient, eq[i]); end
      n_checks++; if (bus.remainder !== er[i]) begin n_fail++; $display("FAIL sign_r[%0d] got %h want %h", i, bus.remainder, er[i]); end
      n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL sign_latency[%0d] got %0d want 34", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    int lat; bit ba, pv, pb;
    for (int m = 0; m < 2; m++) begin
      run_op(m[0], 32'h12345678, 32'h0, 0, lat, ba, pv, pb);
      n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL dz_latency[%0d] got %0d want 2", m, lat); end
      n_checks++; if (bus.quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL dz_q[%0d] got %h want ffffffff", m, bus.quotient); end
      n_checks++; if (bus.remainder !== 32'h12345678) begin n_fail++; $display("FAIL dz_r[%0d] got %h want 12345678", m, bus.remainder); end
      n_checks++; if (bus.div_by_zero !== 1'b1) begin n_fail++; $display("FAIL dz_flag[%0d] got %b want 1", m, bus.div_by_zero); end
      n_checks++; if (ba !== 1'b1 || pv !== 1'b0 || pb !== 1'b0) begin n_fail++; $display("FAIL dz_handshake[%0d] got busy_all=%b post_valid=%b post_busy=%b want 1 0 0", m, ba, pv, pb); end
    end
  endtask

  task automatic test_boundary();
    int lat; bit ba, pv, pb;
    run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 0, lat, ba, pv, pb);
    n_checks++; if (bus.quotient !== 32'h80000000) begin n_fail++; $display("FAIL ovf_q got %h want 80000000", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL ovf_r got %h want 0", bus.remainder); end
    n_checks++; if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL ovf_dbz got %b want 0", bus.div_by_zero); end
    run_op(1'b0, 32'hFFFFFFFF, 32'h1, 0, lat, ba, pv, pb);
    n_checks++; if (bus.quotient !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL umax_q got %h want ffffffff", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL umax_r got %h want 0", bus.remainder); end
  endtask

  task automatic test_start_while_busy();
    int lat; bit ba, pv, pb;
    run_op(1'b0, 32'd100, 32'd7, 5, lat, ba, pv, pb);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL busy_start_latency got %0d want 34", lat); end
    n_checks++; if (bus.quotient !== 32'd14 || bus.remainder !== 32'd2) begin n_fail++; $display("FAIL busy_start_result got q=%0d r=%0d want q=14 r=2", bus.quotient, bus.remainder); end
    n_checks++; if (pb !== 1'b0) begin n_fail++; $display("FAIL busy_start_not_queued got busy=%b want 0", pb); end
  endtask

  task automatic test_flush();
    int lat; bit ba, pv, pb;
    run_op(1'b0, 32'hFFFFFFFF, 32'h1, 0, lat, ba, pv, pb);
    bus.start = 1'b1; bus.signed_en = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got %b want 1", bus.busy); end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    n_checks++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b want 0", bus.valid); end
    n_checks++; if (bus.quotient !== 32'hFFFFFFFF || bus.remainder !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL flush_hold got q=%h r=%h dbz=%b want ffffffff 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    run_op(1'b0, 32'd9, 32'd3, 0, lat, ba, pv, pb);
    n_checks++; if (lat + 12 !== 46) begin n_fail++; $display("FAIL flush_restart_cycle got %0d want 46", lat + 12); end
    n_checks++; if (bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin n_fail++; $display("FAIL flush_restart_result got q=%0d r=%0d want 3 0", bus.quotient, bus.remainder); end
  endtask

  task automatic test_reset_mid();
    int nv;
    bus.start = 1'b1; bus.signed_en = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hs got busy=%b valid=%b want 0 0", bus.busy, bus.valid); end
    n_checks++; if (bus.quotient !== 32'h0 || bus.remainder !== 32'h0 || bus.div_by_zero !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs got q=%h r=%h dbz=%b want 0 0 0", bus.quotient, bus.remainder, bus.div_by_zero);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    nv = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.valid || bus.busy) nv++; end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL rst_mid_no_valid got %0d active cycles want 0", nv); end
  endtask

  task automatic test_start_flush();
    int nv;
    bus.start = 1'b1; bus.flush = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL start_flush_busy got %b want 0", bus.busy); end
    nv = 0;
    repeat (40) begin @(posedge clk); #1; if (bus.valid) nv++; end
    n_checks++; if (nv !== 0) begin n_fail++; $display("FAIL start_flush_valid got %0d want 0", nv); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_boundary();
    test_start_while_busy();
    test_flush();
    test_reset_mid();
    test_start_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
